// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder
package serial_add_pkg;

  localparam int SERIAL_ADD_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - operation request/result bundle; SERIAL_ADD_SUB_EN adds sub
interface serial_add_ctrl_if #(
  parameter int WIDTH = serial_add_pkg::SERIAL_ADD_WIDTH_DEF
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl_full_adder_bit.sv
// rtl/serial_add_ctrl_full_adder_bit.sv - 1-bit full adder from two half adders
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic h1_s;
  logic h1_c;
  logic h2_c;

  assign h1_s = a ^ b;
  assign h1_c = a & b;
  assign s    = h1_s ^ cin;
  assign h2_c = h1_s & cin;
  assign cout = h1_c | h2_c;
endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder, one bit per cycle through a shared full adder.
// SERIAL_ADD_SUB_EN adds a sub input that turns the operation into a - b.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH_DEF
) (
  input logic               clk,
  input logic               rst,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_s;
  logic             fa_c;

  full_adder_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // LSB-first: each new sum bit enters at the MSB, so after WIDTH shifts the word is aligned
  always_comb begin
    res_next            = res_sh >> 1;
    res_next[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
`ifdef SERIAL_ADD_SUB_EN
            // two's complement subtract: ~b with carry-in of one
            b_sh   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub;
`else
            b_sh   <= bus.b;
            carry  <= 1'b0;
`endif
            res_sh <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res_sh <= res_next;
          carry  <= fa_c;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum_q  <= res_next;
            cout_q <= fa_c;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule
